// File: rtl/led_frame_sequencer_if.sv
// Signal bundle between the LED frame sequencer and its decoder/synchronizer/reshaper neighbours.
interface led_frame_sequencer_if #(
  parameter int BITS_PER_LED = 24
);
  logic                    i_line;
  logic                    i_bit_valid;
  logic                    i_bit_value;
  logic                    o_passthru_en;
  logic [BITS_PER_LED-1:0] o_led_data;
  logic                    o_led_update;
  logic                    o_frame_err;
  logic                    o_busy;
  logic [15:0]             o_frame_count;

  modport master (
    output i_line, i_bit_valid, i_bit_value,
    input  o_passthru_en, o_led_data, o_led_update, o_frame_err, o_busy, o_frame_count
  );

  modport slave (
    input  i_line, i_bit_valid, i_bit_value,
    output o_passthru_en, o_led_data, o_led_update, o_frame_err, o_busy, o_frame_count
  );
endinterface

// File: rtl/led_frame_sequencer.sv
// Frame-level controller for a single-LED serial chain: captures the first BITS_PER_LED bits
// of each frame, then forwards. Optional frame counter enabled by macro LED_FRAME_STATS_EN.
module led_frame_sequencer #(
  parameter int BITS_PER_LED = 24,
  parameter int RESET_CYCLES = 2500
) (
  input  logic                   i_clk,
  input  logic                   i_reset_n,
  led_frame_sequencer_if.slave   bus
);
  localparam int GAP_W = $clog2(RESET_CYCLES + 1);
  localparam int CNT_W = $clog2(BITS_PER_LED + 1);

  typedef enum logic [1:0] {
    SYNC    = 2'd0,
    CAPTURE = 2'd1,
    FORWARD = 2'd2
  } state_t;

  state_t                  state;
  logic [GAP_W-1:0]        gap_cnt;
  logic [CNT_W-1:0]        bit_cnt;
  logic [BITS_PER_LED-1:0] staging;
  logic [BITS_PER_LED-1:0] led_data;
  logic                    passthru_en;
  logic                    led_update;
  logic                    frame_err;
  logic                    busy;
  logic                    gap_evt;

  // Saturating counter guarantees one gap_evt per low period regardless of its length.
  assign gap_evt = !bus.i_line && (gap_cnt == GAP_W'(RESET_CYCLES - 1));

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      gap_cnt <= '0;
    end else if (bus.i_line) begin
      gap_cnt <= '0;
    end else if (gap_cnt != GAP_W'(RESET_CYCLES)) begin
      gap_cnt <= gap_cnt + GAP_W'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state       <= SYNC;
      bit_cnt     <= '0;
      staging     <= '0;
      led_data    <= '0;
      passthru_en <= 1'b0;
      led_update  <= 1'b0;
      frame_err   <= 1'b0;
      busy        <= 1'b0;
    end else begin
      led_update <= 1'b0;
      frame_err  <= 1'b0;
      case (state)
        SYNC: begin
          busy <= 1'b0;
          if (gap_evt) state <= CAPTURE;
        end
        CAPTURE: begin
          // gap_evt takes priority; a coincident bit is dropped.
          if (gap_evt) begin
            if (bit_cnt != '0) frame_err <= 1'b1;
            bit_cnt <= '0;
            busy    <= 1'b0;
          end else if (bus.i_bit_valid) begin
            staging <= (staging << 1) | BITS_PER_LED'(bus.i_bit_value);
            bit_cnt <= bit_cnt + CNT_W'(1);
            busy    <= 1'b1;
            if (bit_cnt == CNT_W'(BITS_PER_LED - 1)) begin
              state       <= FORWARD;
              passthru_en <= 1'b1;
            end
          end
        end
        FORWARD: begin
          if (gap_evt) begin
            led_data    <= staging;
            led_update  <= 1'b1;
            passthru_en <= 1'b0;
            bit_cnt     <= '0;
            busy        <= 1'b0;
            state       <= CAPTURE;
          end
        end
        default: begin
          state <= SYNC;
          busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef LED_FRAME_STATS_EN
  logic [15:0] frame_count;

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      frame_count <= '0;
    end else if (state == FORWARD && gap_evt) begin
      frame_count <= frame_count + 16'd1;
    end
  end

  assign bus.o_frame_count = frame_count;
`else
  assign bus.o_frame_count = '0;
`endif

  assign bus.o_passthru_en = passthru_en;
  assign bus.o_led_data    = led_data;
  assign bus.o_led_update  = led_update;
  assign bus.o_frame_err   = frame_err;
  assign bus.o_busy        = busy;
endmodule

// File: tb/tb_led_frame_sequencer.sv
// Directed self-checking bench for led_frame_sequencer (RESET_CYCLES=16, BITS_PER_LED=24).
module tb_led_frame_sequencer;
  localparam int BITS = 24;
  localparam int RC   = 16;

  logic clk;
  logic reset_n;
  int   n_cmp;
  int   n_bad;
  int   upd_cnt;
  int   err_cnt;
  int   upd_mark;
  int   err_mark;

  led_frame_sequencer_if #(.BITS_PER_LED(BITS)) bus ();

  led_frame_sequencer #(
    .BITS_PER_LED(BITS),
    .RESET_CYCLES(RC)
  ) dut (
    .i_clk     (clk),
    .i_reset_n (reset_n),
    .bus       (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Apply inputs for one cycle; observe registered outputs 1ns after the edge.
  task automatic step(input logic line, input logic valid, input logic value);
    bus.i_line      = line;
    bus.i_bit_valid = valid;
    bus.i_bit_value = value;
    @(posedge clk);
    #1;
    if (bus.o_led_update) upd_cnt++;
    if (bus.o_frame_err)  err_cnt++;
  endtask

  task automatic send_bits(input logic [31:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) step(1'b1, 1'b1, v[i]);
  endtask

  task automatic low(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    n_cmp   = 0;
    n_bad   = 0;
    upd_cnt = 0;
    err_cnt = 0;
    reset_n = 1'b0;
    bus.i_line      = 1'b1;
    bus.i_bit_valid = 1'b0;
    bus.i_bit_value = 1'b0;
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    check("rst_passthru", 32'(bus.o_passthru_en), 32'd0);
    check("rst_data",     32'(bus.o_led_data),    32'd0);
    check("rst_busy",     32'(bus.o_busy),        32'd0);
    check("rst_update",   32'(bus.o_led_update),  32'd0);
    check("rst_err",      32'(bus.o_frame_err),   32'd0);
    check("rst_count",    32'(bus.o_frame_count), 32'd0);
    reset_n = 1'b1;

    // 1: bits before any gap are ignored
    send_bits(32'hA5C3F0, 24);
    check("s1_passthru", 32'(bus.o_passthru_en), 32'd0);
    check("s1_busy",     32'(bus.o_busy),        32'd0);
    check("s1_updates",  32'(upd_cnt),           32'd0);
    check("s1_data",     32'(bus.o_led_data),    32'd0);

    // 2: full frame plus extra bits, latched at gap
    low(RC);
    step(1'b1, 1'b0, 1'b0);
    send_bits(32'h12AB34 >> 1, 23);
    check("s2_pt_bit23",   32'(bus.o_passthru_en), 32'd0);
    check("s2_busy_bit23", 32'(bus.o_busy),        32'd1);
    send_bits(32'h0, 1);
    check("s2_pt_bit24",   32'(bus.o_passthru_en), 32'd1);
    send_bits(32'h5A, 8);
    check("s2_pt_extra",   32'(bus.o_passthru_en), 32'd1);
    low(RC - 1);
    check("s2_pt_gap15",   32'(bus.o_passthru_en), 32'd1);
    check("s2_upd_gap15",  32'(upd_cnt),           32'd0);
    low(1);
    check("s2_update",     32'(bus.o_led_update),  32'd1);
    check("s2_pt_after",   32'(bus.o_passthru_en), 32'd0);
    check("s2_data",       32'(bus.o_led_data),    32'h12AB34);
    step(1'b1, 1'b0, 1'b0);
    check("s2_update_1cy", 32'(bus.o_led_update),  32'd0);
    check("s2_upd_total",  32'(upd_cnt),           32'd1);

    // 2b: a 15-cycle low is not a gap
    send_bits(32'h654321, 24);
    low(RC - 1);
    step(1'b1, 1'b0, 1'b0);
    check("s2b_pt",      32'(bus.o_passthru_en), 32'd1);
    check("s2b_data",    32'(bus.o_led_data),    32'h12AB34);
    check("s2b_upd",     32'(upd_cnt),           32'd1);
    low(RC);
    check("s2b_data2",   32'(bus.o_led_data),    32'h654321);

    // 3: partial frame gives frame_err, data retained
    step(1'b1, 1'b0, 1'b0);
    send_bits(32'h2AB, 10);
    err_mark = err_cnt;
    low(RC);
    check("s3_err",      32'(bus.o_frame_err),   32'd1);
    check("s3_data",     32'(bus.o_led_data),    32'h654321);
    check("s3_busy",     32'(bus.o_busy),        32'd0);
    step(1'b1, 1'b0, 1'b0);
    check("s3_err_1cy",  32'(err_cnt - err_mark), 32'd1);
    send_bits(32'h00FF00, 24);
    low(RC);
    check("s3_data2",    32'(bus.o_led_data),    32'h00FF00);

    // 4: 24th bit coincident with gap_evt is dropped
    step(1'b1, 1'b0, 1'b0);
    upd_mark = upd_cnt;
    send_bits(32'h7FFFFF, 23);
    low(RC - 1);
    step(1'b0, 1'b1, 1'b1);
    check("s4_err",      32'(bus.o_frame_err),   32'd1);
    check("s4_pt",       32'(bus.o_passthru_en), 32'd0);
    check("s4_data",     32'(bus.o_led_data),    32'h00FF00);
    check("s4_upd",      32'(upd_cnt - upd_mark), 32'd0);
    step(1'b1, 1'b0, 1'b0);
    send_bits(32'hC0FFEE, 24);
    upd_mark = upd_cnt;
    low(40);
    check("s4_long_upd", 32'(upd_cnt - upd_mark), 32'd1);
    check("s4_data2",    32'(bus.o_led_data),    32'hC0FFEE);

    // 5: reset while forwarding, then resync required
    step(1'b1, 1'b0, 1'b0);
    send_bits(32'h111111, 24);
    check("s5_pt_fwd",   32'(bus.o_passthru_en), 32'd1);
    reset_n = 1'b0;
    step(1'b1, 1'b0, 1'b0);
    reset_n = 1'b1;
    check("s5_pt",       32'(bus.o_passthru_en), 32'd0);
    check("s5_data",     32'(bus.o_led_data),    32'd0);
    check("s5_busy",     32'(bus.o_busy),        32'd0);
    check("s5_count",    32'(bus.o_frame_count), 32'd0);
    upd_mark = upd_cnt;
    send_bits(32'h222222, 24);
    check("s5_pt_ign",   32'(bus.o_passthru_en), 32'd0);
    check("s5_busy_ign", 32'(bus.o_busy),        32'd0);
    low(RC);
    check("s5_upd",      32'(upd_cnt - upd_mark), 32'd0);
    check("s5_data_ign", 32'(bus.o_led_data),    32'd0);
    step(1'b1, 1'b0, 1'b0);
    send_bits(32'h333333, 24);
    low(RC);
    check("s5_data2",    32'(bus.o_led_data),    32'h333333);

    // 6: two more good frames and one errored frame -> 3 frames since reset
    step(1'b1, 1'b0, 1'b0);
    send_bits(32'h444444, 24);
    low(RC);
    step(1'b1, 1'b0, 1'b0);
    send_bits(32'h5, 5);
    low(RC);
    step(1'b1, 1'b0, 1'b0);
    send_bits(32'h666666, 24);
    low(RC);
    check("s6_data",     32'(bus.o_led_data),    32'h666666);
`ifdef LED_FRAME_STATS_EN
    check("s6_count",    32'(bus.o_frame_count), 32'd3);
`else
    check("s6_count",    32'(bus.o_frame_count), 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
